// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC engine: FSM states, Q8.8 scaling and saturation limits.
package neuron_pkg;

  typedef enum logic [1:0] {
    STANDBY = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    SCALE   = 2'd3
  } state_t;

  localparam int FRAC_BITS = 8;

  localparam logic [15:0] QMAX = 16'h7FFF;
  localparam logic [15:0] QMIN = 16'h8000;

endpackage

// File: rtl/neuron_saturate.sv
// Converts the wide accumulator back to Q8.8: arithmetic shift, signed saturation and,
// when NEURON_RELU_EN is defined, a clamp at zero from below.
module neuron_saturate import neuron_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic        [DATA_WIDTH-1:0] value_o
);

  localparam logic [DATA_WIDTH-1:0] SAT_HI =
    (DATA_WIDTH == 16) ? DATA_WIDTH'(QMAX) : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_LO =
    (DATA_WIDTH == 16) ? DATA_WIDTH'(QMIN) : {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic signed [ACC_WIDTH-1:0]  hiExt;
  logic signed [ACC_WIDTH-1:0]  loExt;
  logic        [DATA_WIDTH-1:0] satVal;

  assign shifted = acc_i >>> FRAC_BITS;
  assign hiExt   = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, SAT_HI};
  assign loExt   = {{(ACC_WIDTH-DATA_WIDTH){1'b1}}, SAT_LO};

  always_comb begin
    satVal = shifted[DATA_WIDTH-1:0];
    if (shifted > hiExt) begin
      satVal = SAT_HI;
    end else if (shifted < loExt) begin
      satVal = SAT_LO;
    end
`ifdef NEURON_RELU_EN
    value_o = satVal[DATA_WIDTH-1] ? '0 : satVal;
`else
    value_o = satVal;
`endif
  end

endmodule

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate engine evaluating one neuron from weight/activation RAMs.
// Optional ReLU output stage is selected with the NEURON_RELU_EN macro.
module neuron_mac import neuron_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] count_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic [ADDR_WIDTH-1:0] w_addr_o,
  input  logic [DATA_WIDTH-1:0] w_rdata_i,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  input  logic [DATA_WIDTH-1:0] x_rdata_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  output logic                  finished_o
);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]        count_q, count_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         pvalid_q, pvalid_d;
  logic [DATA_WIDTH-1:0]        result_q, result_d;
  logic                         resultValid_q, resultValid_d;
  logic                         finished_q, finished_d;

  logic [ADDR_WIDTH-1:0]        lastIdx;
  logic signed [2*DATA_WIDTH-1:0] wExt, xExt, product;
  logic signed [ACC_WIDTH-1:0]  productExt;
  logic [DATA_WIDTH-1:0]        satValue;

  assign lastIdx    = count_q - 1'b1;
  assign wExt       = {{DATA_WIDTH{w_rdata_i[DATA_WIDTH-1]}}, w_rdata_i};
  assign xExt       = {{DATA_WIDTH{x_rdata_i[DATA_WIDTH-1]}}, x_rdata_i};
  assign product    = wExt * xExt;
  assign productExt = {{(ACC_WIDTH-2*DATA_WIDTH){product[2*DATA_WIDTH-1]}}, product};

  neuron_saturate #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_saturate (
    .acc_i   (acc_q),
    .value_o (satValue)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= STANDBY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STANDBY: if (start_i) state_d = (count_i != '0) ? FETCH : SCALE;
      FETCH:   if (idx_q == lastIdx) state_d = DRAIN;
      DRAIN:   state_d = SCALE;
      SCALE:   state_d = STANDBY;
      default: state_d = STANDBY;
    endcase
  end

  // RAM addresses are combinational so read data lines up with pvalid one cycle later.
  always_comb begin
    w_addr_o      = '0;
    x_addr_o      = '0;
    count_d       = count_q;
    base_d        = base_q;
    idx_d         = idx_q;
    acc_d         = pvalid_q ? (acc_q + productExt) : acc_q;
    pvalid_d      = (state_q == FETCH);
    result_d      = result_q;
    resultValid_d = 1'b0;
    finished_d    = finished_q;
    case (state_q)
      STANDBY: begin
        if (start_i) begin
          count_d    = count_i;
          base_d     = base_addr_i;
          idx_d      = '0;
          acc_d      = '0;
          finished_d = 1'b0;
        end
      end
      FETCH: begin
        w_addr_o = base_q + idx_q;
        x_addr_o = idx_q;
        idx_d    = idx_q + 1'b1;
      end
      SCALE: begin
        result_d      = satValue;
        resultValid_d = 1'b1;
        finished_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q       <= '0;
      base_q        <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      pvalid_q      <= 1'b0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      finished_q    <= 1'b1;
    end else begin
      count_q       <= count_d;
      base_q        <= base_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      pvalid_q      <= pvalid_d;
      result_q      <= result_d;
      resultValid_q <= resultValid_d;
      finished_q    <= finished_d;
    end
  end

  assign result_o       = result_q;
  assign result_valid_o = resultValid_q;
  assign finished_o     = finished_q;

endmodule
